// File: rtl/vedic_mult_pipe.sv
// Pipelined Urdhva-Tiryagbhyam multiplier, signed/unsigned per beat; optional accumulator under VEDIC_MULT_ACC_EN.
// Latency 3 cycles from input transfer to out_vld, 1 beat/cycle sustained.
// Backpressure: global stall, every stage holds while out_valid && !out_ready.

module vedic_core #(
  parameter int N = 2
) (
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic [2*N-1:0] p
);

  if (N == 2) begin : g_cell
    // 2x2 vertical-and-crosswise cell: column sums with explicit carries
    logic x_dat, y_dat, t_dat, k_dat;
    assign x_dat = a[1] & b[0];
    assign y_dat = a[0] & b[1];
    assign t_dat = a[1] & b[1];
    assign k_dat = x_dat & y_dat;
    assign p = {t_dat & k_dat, t_dat ^ k_dat, x_dat ^ y_dat, a[0] & b[0]};
  end else begin : g_rec
    localparam int M = N / 2;
    logic [N-1:0] qp [4];
    logic [N:0]   mid;

    for (genvar q = 0; q < 4; q++) begin : g_q
      vedic_core #(.N(M)) u_q (
        .a ((q % 2 == 1) ? a[N-1:M] : a[M-1:0]),
        .b ((q / 2 == 1) ? b[N-1:M] : b[M-1:0]),
        .p (qp[q])
      );
    end

    // hh and ll occupy disjoint halves, so they concatenate; only the cross terms add
    assign mid = {1'b0, qp[1]} + {1'b0, qp[2]};
    assign p   = {qp[3], qp[0]} + ({{(N-1){1'b0}}, mid} << M);
  end

endmodule

// Three-stage multiplier top: S1 sign/magnitude, S2 quadrant products, S3 combine and negate.
// Latency 3 cycles, full throughput; VEDIC_MULT_ACC_EN adds acc_clr/out_acc running sum.
// Backpressure: in_ready = !out_valid || out_ready; all stages freeze together on stall.
module vedic_mult_pipe #(
  parameter int WIDTH     = 16,
  parameter int ACC_GUARD = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  input  logic                 in_signed,
`ifdef VEDIC_MULT_ACC_EN
  input  logic                 acc_clr,
  output logic [2*WIDTH+ACC_GUARD-1:0] out_acc,
`endif
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   out_p
);

  localparam int H = WIDTH / 2;

  if ((WIDTH & (WIDTH - 1)) != 0 || WIDTH < 4 || WIDTH > 32 || ACC_GUARD < 1) begin : g_bad_param
    $error("vedic_mult_pipe: WIDTH must be a power of two in 4..32 and ACC_GUARD >= 1");
  end

  logic adv;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // S1: sign and operand magnitudes
  logic [WIDTH-1:0] a_mag, b_mag;
  assign a_mag = (in_signed && in_a[WIDTH-1]) ? -in_a : in_a;
  assign b_mag = (in_signed && in_b[WIDTH-1]) ? -in_b : in_b;

  logic             s1_vld, s1_sign;
  logic [WIDTH-1:0] s1_a, s1_b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld  <= 1'b0;
      s1_sign <= 1'b0;
      s1_a    <= '0;
      s1_b    <= '0;
    end else if (adv) begin
      s1_vld <= in_valid;
      if (in_valid) begin
        s1_sign <= in_signed & (in_a[WIDTH-1] ^ in_b[WIDTH-1]);
        s1_a    <= a_mag;
        s1_b    <= b_mag;
      end
    end
  end

  // S2: quadrants q0=al*bl, q1=ah*bl, q2=al*bh, q3=ah*bh
  logic [WIDTH-1:0] qp [4];
  for (genvar q = 0; q < 4; q++) begin : g_quad
    vedic_core #(.N(H)) u_quad (
      .a ((q % 2 == 1) ? s1_a[WIDTH-1:H] : s1_a[H-1:0]),
      .b ((q / 2 == 1) ? s1_b[WIDTH-1:H] : s1_b[H-1:0]),
      .p (qp[q])
    );
  end

  logic             s2_vld, s2_sign;
  logic [WIDTH-1:0] s2_q [4];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_vld  <= 1'b0;
      s2_sign <= 1'b0;
      for (int i = 0; i < 4; i++) s2_q[i] <= '0;
    end else if (adv) begin
      s2_vld <= s1_vld;
      if (s1_vld) begin
        s2_sign <= s1_sign;
        for (int i = 0; i < 4; i++) s2_q[i] <= qp[i];
      end
    end
  end

  // S3: recombine quadrants, then apply sign; negating zero yields zero
  logic [WIDTH:0]     mid;
  logic [2*WIDTH-1:0] p_mag, p_nxt;
  assign mid   = {1'b0, s2_q[1]} + {1'b0, s2_q[2]};
  assign p_mag = {s2_q[3], s2_q[0]} + ({{(WIDTH-1){1'b0}}, mid} << H);
  assign p_nxt = s2_sign ? -p_mag : p_mag;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_p     <= '0;
    end else if (adv) begin
      out_valid <= s2_vld;
      if (s2_vld) out_p <= p_nxt;
    end
  end

`ifdef VEDIC_MULT_ACC_EN
  logic s1_mode, s2_mode, s1_clr, s2_clr;
  logic [2*WIDTH+ACC_GUARD-1:0] p_ext;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_mode <= 1'b0;
      s1_clr  <= 1'b0;
      s2_mode <= 1'b0;
      s2_clr  <= 1'b0;
    end else if (adv) begin
      if (in_valid) begin
        s1_mode <= in_signed;
        s1_clr  <= acc_clr;
      end
      if (s1_vld) begin
        s2_mode <= s1_mode;
        s2_clr  <= s1_clr;
      end
    end
  end

  // signed products extend with their sign bit, unsigned ones with zeros
  assign p_ext = s2_mode ? {{ACC_GUARD{p_nxt[2*WIDTH-1]}}, p_nxt}
                         : {{ACC_GUARD{1'b0}}, p_nxt};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_acc <= '0;
    end else if (adv && s2_vld) begin
      out_acc <= (s2_clr ? '0 : out_acc) + p_ext;
    end
  end
`endif

endmodule

// File: tb/tb_vedic_mult_pipe.sv
// Randomised and directed bench for vedic_mult_pipe (WIDTH=16) against an arithmetic product model.
module tb_vedic_mult_pipe;
  localparam int W = 16;
  localparam int G = 8;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           in_valid = 1'b0;
  logic           in_signed = 1'b0;
  logic           out_ready = 1'b1;
  logic [W-1:0]   in_a = '0;
  logic [W-1:0]   in_b = '0;
  logic           in_ready;
  logic           out_valid;
  logic [2*W-1:0] out_p;
`ifdef VEDIC_MULT_ACC_EN
  logic             acc_clr = 1'b0;
  logic [2*W+G-1:0] out_acc;
`endif

  int checks = 0;
  int errors = 0;

  vedic_mult_pipe #(.WIDTH(W), .ACC_GUARD(G)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_signed (in_signed),
`ifdef VEDIC_MULT_ACC_EN
    .acc_clr   (acc_clr),
    .out_acc   (out_acc),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_p     (out_p)
  );

  always #5 clk = ~clk;

  function automatic longint ref_prod(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    longint pa, pb;
    pa = s ? longint'($signed(a)) : longint'(a);
    pb = s ? longint'($signed(b)) : longint'(b);
    return pa * pb;
  endfunction

  function automatic logic [W-1:0] pick();
    case ($urandom_range(7))
      0: return '0;
      1: return 16'h8000;
      2: return 16'hFFFF;
      3: return 16'h7FFF;
      default: return W'($urandom);
    endcase
  endfunction

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || out_p !== '0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_state: out_valid=%b out_p=%h in_ready=%b, want 0 0 1", out_valid, out_p, in_ready);
    end
`ifdef VEDIC_MULT_ACC_EN
    checks++;
    if (out_acc !== '0) begin
      errors++;
      $display("FAIL reset_acc: out_acc=%h, want 0", out_acc);
    end
`endif
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_single(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                             input logic [2*W-1:0] exp, input string name);
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b1; in_a = a; in_b = b; in_signed = s;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_ready: in_ready=%b, want 1", name, in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      checks++;
      if (c == 3) begin
        if (out_valid !== 1'b1 || out_p !== exp) begin
          errors++;
          $display("FAIL %s: cycle %0d out_valid=%b out_p=%h, want 1 %h", name, c, out_valid, out_p, exp);
        end
      end else if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL %s_latency: cycle %0d out_valid=%b, want 0", name, c, out_valid);
      end
    end
  endtask

  task automatic test_unsigned();
    test_single(16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001, "u_ffff_ffff");
    test_single(16'h1234, 16'h5678, 1'b0, 32'h06260060, "u_1234_5678");
  endtask

  task automatic test_signed();
    test_single(16'hFFFF, 16'hFFFF, 1'b1, 32'h00000001, "s_m1_m1");
    test_single(16'h8000, 16'h8000, 1'b1, 32'h40000000, "s_min_min");
    test_single(16'h8000, 16'h7FFF, 1'b1, 32'hC0008000, "s_min_max");
    test_single(16'h0000, 16'h8000, 1'b1, 32'h00000000, "s_zero_min");
  endtask

  // rnd=0: back-to-back beats, alternating mode, out_ready low in cycles 4..7
  task automatic run_stream(input int n, input bit rnd, input string name);
    int sent = 0, got = 0, cyc = 0;
    bit stalled = 1'b0, accepted = 1'b0;
    logic [2*W-1:0] held = '0, e;
    logic [2*W-1:0] q[$];
    in_valid = 1'b0;
    @(posedge clk); #1;
    while ((sent < n || got < n) && cyc < 8 * n + 200) begin
      if (!in_valid || accepted) begin
        if (sent < n && (!rnd || $urandom_range(3) != 0)) begin
          in_valid = 1'b1;
          in_a = pick();
          in_b = pick();
          in_signed = rnd ? 1'($urandom_range(1)) : 1'(sent % 2);
        end else begin
          in_valid = 1'b0;
        end
      end
      out_ready = rnd ? ($urandom_range(2) != 0) : !(cyc >= 4 && cyc <= 7);
      @(negedge clk);
      checks++;
      if (in_ready !== !(out_valid && !out_ready)) begin
        errors++;
        $display("FAIL %s_in_ready: cycle %0d in_ready=%b out_valid=%b out_ready=%b", name, cyc, in_ready, out_valid, out_ready);
      end
      if (stalled) begin
        checks++;
        if (out_valid !== 1'b1 || out_p !== held) begin
          errors++;
          $display("FAIL %s_hold: cycle %0d out_valid=%b out_p=%h, want 1 %h", name, cyc, out_valid, out_p, held);
        end
      end
      if (out_valid === 1'b1 && out_ready) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL %s_spurious: cycle %0d out_p=%h with no beat outstanding", name, cyc, out_p);
        end else begin
          e = q.pop_front();
          got++;
          if (out_p !== e) begin
            errors++;
            $display("FAIL %s_product: beat %0d out_p=%h, want %h", name, got - 1, out_p, e);
          end
        end
      end
      stalled = (out_valid === 1'b1) && !out_ready;
      held = out_p;
      accepted = in_valid && (in_ready === 1'b1);
      if (accepted) begin
        q.push_back((2*W)'(ref_prod(in_a, in_b, in_signed)));
        sent++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    checks++;
    if (got != n || q.size() != 0) begin
      errors++;
      $display("FAIL %s_count: received %0d of %0d, %0d outstanding", name, got, n, q.size());
    end
  endtask

  task automatic test_back_to_back();
    run_stream(8, 1'b0, "b2b");
  endtask

  task automatic test_random();
    run_stream(10000, 1'b1, "rand");
  endtask

  task automatic test_reset_inflight();
    out_ready = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; in_a = W'(k + 5); in_b = W'(k + 7); in_signed = 1'b0;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL rst_inflight_pre: out_valid=%b, want 1", out_valid);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_p !== '0) begin
      errors++;
      $display("FAIL rst_async: out_valid=%b out_p=%h, want 0 0", out_valid, out_p);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL rst_stale: cycle %0d out_valid=%b out_p=%h, want 0", c, out_valid, out_p);
      end
    end
    test_single(16'h0003, 16'h0005, 1'b0, 32'h0000000F, "post_reset");
  endtask

`ifdef VEDIC_MULT_ACC_EN
  task automatic test_acc();
    int n = 302, sent = 0, got = 0, cyc = 0;
    logic [2*W+G-1:0] acc_m = '0, e;
    logic [2*W+G-1:0] q[$];
    out_ready = 1'b1;
    @(posedge clk); #1;
    while (got < n && cyc < n + 50) begin
      if (sent < n) begin
        in_valid = 1'b1;
        if (sent == 0) begin
          in_a = 16'd3; in_b = 16'd4; in_signed = 1'b0; acc_clr = 1'b1;
        end else if (sent == 1) begin
          in_a = 16'hFFFF; in_b = 16'h0002; in_signed = 1'b1; acc_clr = 1'b0;
        end else begin
          in_a = 16'hFFFF; in_b = 16'hFFFF; in_signed = 1'b0; acc_clr = (sent == 2);
        end
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      if (out_valid === 1'b1) begin
        checks++;
        e = q.pop_front();
        got++;
        if (out_acc !== e) begin
          errors++;
          $display("FAIL acc_value: beat %0d out_acc=%h, want %h", got - 1, out_acc, e);
        end
      end
      if (in_valid && in_ready === 1'b1) begin
        acc_m = (acc_clr ? '0 : acc_m) + (2*W+G)'(ref_prod(in_a, in_b, in_signed));
        q.push_back(acc_m);
        sent++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0;
    acc_clr = 1'b0;
    checks++;
    if (got != n) begin
      errors++;
      $display("FAIL acc_count: received %0d of %0d", got, n);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_back_to_back();
    test_random();
    test_reset_inflight();
`ifdef VEDIC_MULT_ACC_EN
    test_acc();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
